uart_rx_fifo: RTL and testbench

Receive-side byte buffer that sits directly downstream of uart_rx. It captures each received word on the rising edge of uart_rx's ready output and stores it in a circular FIFO. The buffered words are presented to the consumer (command parser or bus bridge) through a first-word-fall-through read port with full, empty, count and sticky overflow status.

---
 rtl/uart_rx_fifo.sv | 86 ++++++++
 tb/tb_uart_rx_fifo.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx_fifo : edge-triggered capture of uart_rx words into an FWFT FIFO  |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_ready,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  clear_overflow
);

    localparam int                DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] C_DEPTH = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_rx_ready_q;
    logic                  r_overflow;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_wr_en;
    logic                  w_drop;

    // A push while full is only accepted when a pop frees the head slot in the same cycle.
    assign w_push  = rx_ready & ~r_rx_ready_q;
    assign w_pop   = rd_en & ~empty;
    assign w_wr_en = w_push & (~full | w_pop);
    assign w_drop  = w_push & full & ~w_pop;

    assign empty    = (r_count == '0);
    assign full     = (r_count == C_DEPTH);
    assign count    = r_count;
    assign overflow = r_overflow;
    assign rd_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset && w_wr_en) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

    // Edge detector comes out of reset high so a ready level held across release does not push.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_rx_ready_q <= 1'b1;
            r_overflow   <= 1'b0;
        end else begin
            r_rx_ready_q <= rx_ready;
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + (DEPTH_LOG2 + 1)'(1);
                2'b01:   r_count <= r_count - (DEPTH_LOG2 + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// Testbench for uart_rx_fifo: directed scenarios plus random traffic against a queue model.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready = 1'b0;
    logic       rd_en = 1'b0;
    logic       clear_overflow = 1'b0;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    logic [7:0] mq[$];
    bit         movf  = 1'b0;
    bit         mprev = 1'b1;

    uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .rx_data        (rx_data),
        .rx_ready       (rx_ready),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .empty          (empty),
        .full           (full),
        .count          (count),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    always #5 clk = ~clk;

    // One clock: drive at the falling edge, update the model at the rising edge, return at the next falling edge.
    task automatic step(input logic rn, input logic rdy, input logic [7:0] d,
                        input logic rd, input logic clr);
        bit was_full;
        bit push;
        bit pop;
        reset = rn; rx_ready = rdy; rx_data = d; rd_en = rd; clear_overflow = clr;
        @(posedge clk);
        if (!rn) begin
            mq.delete();
            movf  = 1'b0;
            mprev = 1'b1;
        end else begin
            push     = rdy && !mprev;
            pop      = rd && (mq.size() > 0);
            was_full = (mq.size() == 16);
            if (pop) void'(mq.pop_front());
            if (push && was_full && !pop) movf = 1'b1;
            else if (clr) movf = 1'b0;
            if (push && (!was_full || pop)) mq.push_back(d);
            mprev = rdy;
        end
        @(negedge clk);
    endtask

    task automatic push_word(input logic [7:0] d);
        step(1'b1, 1'b1, d, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        total++;
        if ({count, empty, full, overflow} !== {5'd0, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: count=%0d empty=%b full=%b ovf=%b, need 0/1/0/0", count, empty, full, overflow);
        end
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_single();
        push_word(8'hA5);
        total++;
        if ({empty, count, rd_data} !== {1'b0, 5'd1, 8'hA5}) begin
            bad++;
            $display("FAIL single_push: empty=%b count=%0d rd_data=%h, need 0/1/a5", empty, count, rd_data);
        end
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        total++;
        if ({empty, count} !== {1'b1, 5'd0}) begin
            bad++;
            $display("FAIL single_pop: empty=%b count=%0d, need 1/0", empty, count);
        end
        // rd_en while empty must be ignored
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        total++;
        if ({empty, count, overflow} !== {1'b1, 5'd0, 1'b0}) begin
            bad++;
            $display("FAIL pop_empty: empty=%b count=%0d ovf=%b, need 1/0/0", empty, count, overflow);
        end
    endtask

    task automatic test_level_hold();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        total++;
        if ({count, rd_data} !== {5'd1, 8'h3C}) begin
            bad++;
            $display("FAIL level_hold: count=%0d rd_data=%h, need 1/3c", count, rd_data);
        end
        step(1'b1, 1'b1, 8'h11, 1'b1, 1'b0);
        step(1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
        total++;
        if ({count, empty} !== {5'd0, 1'b1}) begin
            bad++;
            $display("FAIL ready_across_reset: count=%0d empty=%b, need 0/1", count, empty);
        end
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_full_overflow();
        for (int i = 0; i < 16; i++) push_word(8'(i));
        total++;
        if ({full, count, overflow} !== {1'b1, 5'd16, 1'b0}) begin
            bad++;
            $display("FAIL fill16: full=%b count=%0d ovf=%b, need 1/16/0", full, count, overflow);
        end
        push_word(8'hFF);
        total++;
        if ({full, count, overflow} !== {1'b1, 5'd16, 1'b1}) begin
            bad++;
            $display("FAIL push_when_full: full=%b count=%0d ovf=%b, need 1/16/1", full, count, overflow);
        end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (rd_data !== 8'(i) || empty !== 1'b0) begin
                bad++;
                $display("FAIL drain_order[%0d]: rd_data=%h empty=%b, need %h/0", i, rd_data, empty, 8'(i));
            end
            step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        total++;
        if ({empty, overflow} !== {1'b1, 1'b1}) begin
            bad++;
            $display("FAIL drained: empty=%b ovf=%b, need 1/1", empty, overflow);
        end
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL clear_overflow: ovf=%b, need 0", overflow);
        end
        // set wins over clear in the same cycle
        for (int i = 0; i < 16; i++) push_word(8'(i + 16));
        step(1'b1, 1'b1, 8'hEE, 1'b0, 1'b1);
        total++;
        if ({overflow, count} !== {1'b1, 5'd16}) begin
            bad++;
            $display("FAIL set_beats_clear: ovf=%b count=%0d, need 1/16", overflow, count);
        end
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_full_push_pop();
        logic [7:0] last;
        step(1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
        total++;
        if ({count, overflow, full} !== {5'd16, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL full_push_pop: count=%0d ovf=%b full=%b, need 16/0/1", count, overflow, full);
        end
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        last = 8'h00;
        for (int i = 0; i < 16; i++) begin
            last = rd_data;
            total++;
            if (rd_data !== mq[0]) begin
                bad++;
                $display("FAIL full_drain[%0d]: rd_data=%h, need %h", i, rd_data, mq[0]);
            end
            step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        total++;
        if ({last, empty} !== {8'h77, 1'b1}) begin
            bad++;
            $display("FAIL last_is_77: last=%h empty=%b, need 77/1", last, empty);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] sent[$];
        logic [7:0] d;
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom);
            sent.push_back(d);
            push_word(d);
            if (i % 2 == 1) begin
                for (int k = 0; k < 2; k++) begin
                    total++;
                    if (rd_data !== sent[0] || empty !== 1'b0) begin
                        bad++;
                        $display("FAIL wrap_order: rd_data=%h empty=%b, need %h/0", rd_data, empty, sent[0]);
                    end
                    void'(sent.pop_front());
                    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
                end
            end
        end
        total++;
        if ({empty, count} !== {1'b1, 5'd0} || sent.size() != 0) begin
            bad++;
            $display("FAIL wrap_end: empty=%b count=%0d, need 1/0", empty, count);
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 7; i++) push_word(8'($urandom));
        total++;
        if (count !== 5'd7) begin
            bad++;
            $display("FAIL pre_reset_count: count=%0d, need 7", count);
        end
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        total++;
        if ({count, empty, overflow} !== {5'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL midstream_reset: count=%0d empty=%b ovf=%b, need 0/1/0", count, empty, overflow);
        end
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        push_word(8'h5A);
        total++;
        if ({rd_data, count} !== {8'h5A, 5'd1}) begin
            bad++;
            $display("FAIL post_reset_push: rd_data=%h count=%0d, need 5a/1", rd_data, count);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            step(($urandom_range(0, 199) != 0), $urandom_range(0, 1), 8'($urandom),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
            total++;
            if (count !== 5'(mq.size()) || empty !== (mq.size() == 0) ||
                full !== (mq.size() == 16) || overflow !== movf ||
                (mq.size() > 0 && rd_data !== mq[0])) begin
                bad++;
                $display("FAIL random[%0d]: count=%0d empty=%b full=%b ovf=%b rd=%h, need count=%0d ovf=%b head=%h",
                         c, count, empty, full, overflow, rd_data, mq.size(), movf,
                         (mq.size() > 0) ? mq[0] : 8'h00);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_level_hold();
        test_full_overflow();
        test_full_push_pop();
        test_wrap();
        test_reset_midstream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
